systolic_feeder: RTL and testbench

Skewing input feeder for the west/north edge of the systolic MAC array. Accepts one LANES-wide operand vector per handshake, buffers a whole tile, then drives each lane into the array with a one-cycle diagonal skew per lane. Each lane's valid is held high for exactly K contiguous cycles per tile, followed by at least one low cycle, which the processing elements need to accumulate and then clear. One instance feeds activations and a second feeds weights.

---
 rtl/systolic_feeder.sv | 146 ++++++++++++++
 tb/tb_systolic_feeder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Skewing operand feeder for the systolic array edge: buffers a tile, then streams it diagonally.
// Optional macro SYSTOLIC_FEEDER_ZERO_GATE_EN zeroes each out_data lane while its valid is low.
module systolic_feeder #(
  parameter int unsigned DW    = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned K_MAX = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*DW-1:0]        in_data,
  input  logic [$clog2(K_MAX+1)-1:0] tile_len,
  output logic [LANES*DW-1:0]        out_data,
  output logic [LANES-1:0]           out_valid,
  output logic                       tile_done,
  output logic                       busy
);

  localparam int unsigned TLW = $clog2(K_MAX + 1);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStream = 2'd1;
  localparam logic [1:0] StGap    = 2'd2;

  if (DEPTH < K_MAX) begin : g_depth_check
    $error("systolic_feeder: DEPTH must be >= K_MAX");
  end

  logic [LANES*DW-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic [1:0]          state_q, state_d;
  logic [TLW-1:0]      beat_q, beat_d;
  logic [TLW-1:0]      k_eff;
  logic                push, pop, last_pop, start_ok;
  logic [LANES*DW-1:0] pop_data;
  logic [LANES-1:0]    done_q;
  logic [LANES-1:0]    lane_busy;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Ready depends only on the registered count, never on a same-cycle pop.
  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == StStream);
  assign last_pop = pop && (beat_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  assign k_eff    = ((tile_len == '0) || (tile_len > TLW'(K_MAX))) ? TLW'(K_MAX) : tile_len;
  assign start_ok = (count_q >= CW'(k_eff));

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StStream;
          beat_d  = k_eff - TLW'(1);
        end
      end
      StStream: begin
        if (beat_q == '0) state_d = StGap;
        else beat_d = beat_q - TLW'(1);
      end
      StGap: begin
        if (start_ok) begin
          state_d = StStream;
          beat_d  = k_eff - TLW'(1);
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
      beat_q   <= '0;
      done_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q   <= count_d;
      state_q   <= state_d;
      beat_q    <= beat_d;
      // Final-pop marker travels alongside lane LANES-1.
      done_q[0] <= last_pop;
      for (int s = 1; s < int'(LANES); s++) done_q[s] <= done_q[s-1];
    end
  end

  assign tile_done = done_q[LANES-1];

  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    logic [i:0]    v_q;
    logic [DW-1:0] d_q [i+1];

    // Data stages load only behind a valid beat so idle lanes keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
        for (int s = 0; s <= i; s++) d_q[s] <= '0;
      end else begin
        v_q[0] <= pop;
        if (pop) d_q[0] <= pop_data[i*DW +: DW];
        for (int s = 1; s <= i; s++) begin
          v_q[s] <= v_q[s-1];
          if (v_q[s-1]) d_q[s] <= d_q[s-1];
        end
      end
    end

    assign out_valid[i] = v_q[i];
    assign lane_busy[i] = |v_q;
`ifdef SYSTOLIC_FEEDER_ZERO_GATE_EN
    assign out_data[i*DW +: DW] = v_q[i] ? d_q[i] : '0;
`else
    assign out_data[i*DW +: DW] = d_q[i];
`endif
  end

  assign busy = (state_q != StIdle) || (|lane_busy);

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder (default parameters).
module tb_systolic_feeder;
  localparam int DW    = 8;
  localparam int LANES = 4;
  localparam int TLW   = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [LANES*DW-1:0]  in_data = '0;
  logic [TLW-1:0]       tile_len = '0;
  logic [LANES*DW-1:0]  out_data;
  logic [LANES-1:0]     out_valid;
  logic                 tile_done;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [LANES-1:0]    v_cap [32];
  logic [LANES*DW-1:0] d_cap [32];
  logic                t_cap [32];
  logic                b_cap [32];

  systolic_feeder #(.DW(8), .LANES(4), .K_MAX(16), .DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .tile_len  (tile_len),
    .out_data  (out_data),
    .out_valid (out_valid),
    .tile_done (tile_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic push_one(input logic [LANES*DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Offset k holds the sample from the k-th cycle after the last push edge.
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      v_cap[k] = out_valid;
      d_cap[k] = out_data;
      t_cap[k] = tile_done;
      b_cap[k] = busy;
    end
  endtask

  task automatic apply_reset;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
    n_checks++; if (tile_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", tile_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %b want 0", busy); end
  endtask

  task automatic test_basic;
    logic [31:0] got, exp;
    logic [LANES*DW-1:0] vec;
    logic [DW-1:0] want0, want3;
    tile_len = 5'd3;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < LANES; i++) vec[i*DW +: DW] = 8'(10*j + i);
      push_one(vec);
    end
    capture(12);
    for (int i = 0; i < LANES; i++) begin
      got = '0; exp = '0;
      for (int k = 0; k < 12; k++) got[k] = v_cap[k][i];
      for (int j = 0; j < 3; j++) exp[2+i+j] = 1'b1;
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL basic_valid lane %0d got %b want %b", i, got[11:0], exp[11:0]);
      end
      for (int j = 0; j < 3; j++) begin
        n_checks++;
        if (d_cap[2+i+j][i*DW +: DW] !== 8'(10*j + i)) begin
          n_fail++;
          $display("FAIL basic_data lane %0d beat %0d got %0d want %0d", i, j,
                   d_cap[2+i+j][i*DW +: DW], 10*j + i);
        end
      end
    end
    got = '0;
    for (int k = 0; k < 12; k++) got[k] = t_cap[k];
    n_checks++;
    if (got !== 32'h80) begin n_fail++; $display("FAIL basic_done got %b want %b", got[11:0], 12'h080); end
    n_checks++;
    if (d_cap[7][3*DW +: DW] !== 8'd23) begin
      n_fail++; $display("FAIL basic_done_data got %0d want 23", d_cap[7][3*DW +: DW]);
    end
`ifdef SYSTOLIC_FEEDER_ZERO_GATE_EN
    want0 = 8'd0; want3 = 8'd0;
`else
    want0 = 8'd20; want3 = 8'd23;
`endif
    n_checks++;
    if (d_cap[11][DW-1:0] !== want0) begin
      n_fail++; $display("FAIL idle_data lane0 got %0d want %0d", d_cap[11][DW-1:0], want0);
    end
    n_checks++;
    if (d_cap[11][3*DW +: DW] !== want3) begin
      n_fail++; $display("FAIL idle_data lane3 got %0d want %0d", d_cap[11][3*DW +: DW], want3);
    end
    n_checks++; if (b_cap[11] !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b want 0", b_cap[11]); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] got, exp;
    logic [LANES*DW-1:0] vec;
    int offs [4] = '{0, 1, 3, 4};
    tile_len = 5'd2;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < LANES; i++) vec[i*DW +: DW] = 8'(40 + 10*j + i);
      push_one(vec);
    end
    capture(10);
    for (int i = 0; i < LANES; i++) begin
      got = '0; exp = '0;
      for (int k = 0; k < 10; k++) got[k] = v_cap[k][i];
      for (int j = 0; j < 4; j++) exp[i+offs[j]] = 1'b1;
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL b2b_valid lane %0d got %b want %b", i, got[9:0], exp[9:0]);
      end
      for (int j = 0; j < 4; j++) begin
        n_checks++;
        if (d_cap[i+offs[j]][i*DW +: DW] !== 8'(40 + 10*j + i)) begin
          n_fail++;
          $display("FAIL b2b_data lane %0d beat %0d got %0d want %0d", i, j,
                   d_cap[i+offs[j]][i*DW +: DW], 40 + 10*j + i);
        end
      end
    end
    got = '0;
    for (int k = 0; k < 10; k++) got[k] = t_cap[k];
    n_checks++;
    if (got !== 32'h90) begin n_fail++; $display("FAIL b2b_done got %b want %b", got[9:0], 10'h090); end
  endtask

  task automatic test_full;
    int seq_in, seq_out, first_low, low_cnt, beats;
    logic rdy_prev;
    apply_reset;
    tile_len  = 5'd16;
    seq_in    = 0; seq_out = 0; first_low = -1; low_cnt = 0; beats = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {LANES{seq_in[7:0]}};
    rdy_prev = in_ready;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      if (rdy_prev) seq_in++;
      in_data  = {LANES{seq_in[7:0]}};
      rdy_prev = in_ready;
      if (!in_ready && c <= 20) begin
        low_cnt++;
        if (first_low < 0) first_low = c;
      end
      if (c == 18) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_rise got %b want 1", in_ready); end
      end
      if (out_valid[0]) begin
        n_checks++;
        if (out_data[DW-1:0] !== seq_out[7:0]) begin
          n_fail++; $display("FAIL full_order cycle %0d got %0d want %0d", c, out_data[DW-1:0], seq_out[7:0]);
        end
        seq_out++;
        if (c <= 34) beats++;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (first_low != 16) begin n_fail++; $display("FAIL full_first_low got %0d want 16", first_low); end
    n_checks++; if (low_cnt != 2) begin n_fail++; $display("FAIL full_low_cycles got %0d want 2", low_cnt); end
    n_checks++; if (beats != 16) begin n_fail++; $display("FAIL full_first_tile got %0d want 16", beats); end
  endtask

  task automatic test_clamp(input logic [TLW-1:0] tl, input string name);
    int beats, dones;
    apply_reset;
    tile_len = tl;
    for (int j = 0; j < 16; j++) push_one({LANES{8'(j)}});
    beats = 0; dones = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (out_valid[0] === 1'b1) beats++;
      if (tile_done === 1'b1) dones++;
    end
    n_checks++; if (beats != 16) begin n_fail++; $display("FAIL %s_beats got %0d want 16", name, beats); end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL %s_done got %0d want 1", name, dones); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy got %b want 0", name, busy); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] got, exp;
    apply_reset;
    tile_len = 5'd5;
    for (int j = 0; j < 5; j++) push_one({LANES{8'(j + 1)}});
    @(posedge clk);
    @(posedge clk);
    #2;
    n_checks++;
    if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL mid_streaming got %b want 1", out_valid[0]); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== '0) begin n_fail++; $display("FAIL mid_valid_clear got %b want 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL mid_data_clear got %h want 0", out_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_clear got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_after got %b want 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after got %b want 1", in_ready); end
    tile_len = 5'd1;
    push_one(32'hA3A2A1A0);
    capture(8);
    for (int i = 0; i < LANES; i++) begin
      got = '0; exp = '0;
      for (int k = 0; k < 8; k++) got[k] = v_cap[k][i];
      exp[2+i] = 1'b1;
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL fresh_valid lane %0d got %b want %b", i, got[7:0], exp[7:0]);
      end
      n_checks++;
      if (d_cap[2+i][i*DW +: DW] !== 8'(160 + i)) begin
        n_fail++; $display("FAIL fresh_data lane %0d got %h want %h", i, d_cap[2+i][i*DW +: DW], 160 + i);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_full;
    test_clamp(5'd0, "tl0");
    test_clamp(5'd20, "tl20");
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
